instr_prefetch_buffer: RTL and testbench

//   Instruction prefetch stage between instruction memory and the decode/execute datapath.

---
 rtl/instr_prefetch_buffer.sv | 137 +++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with a DEPTH-entry {pc,instr} FIFO and redirect flush.
// Optional macro PREFETCH_BYPASS_EN lets a response reach the instr_* outputs in the cycle it arrives.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] occ_reg, occ_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [63:0]   mem_reg [DEPTH];

  logic [CW:0]   credit_sum;
  logic [31:0]   redirect_pc_al;
  logic [63:0]   head;
  logic          issue, resp_drop, resp_keep;
  logic          fifo_valid, bypass_valid, bypass_take;
  logic          pop_fifo, push;
  logic          unused_bits;

  assign unused_bits    = ^redirect_pc[1:0];
  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

  // Every issued request holds a FIFO credit until its word is consumed or dropped.
  assign credit_sum = {1'b0, occ_reg} + {1'b0, outstanding_reg};
  assign imem_req   = reset_n && (state_reg == ST_RUN) && !redirect && (credit_sum < DEPTH_W);
  assign imem_addr  = fetch_pc_reg;
  assign issue      = imem_req && imem_ready;

  assign resp_drop  = imem_rvalid && (drop_cnt_reg != '0);
  assign resp_keep  = imem_rvalid && (drop_cnt_reg == '0) && !redirect;

  assign fifo_valid = (occ_reg != '0);
  assign head       = mem_reg[rd_ptr_reg];

`ifdef PREFETCH_BYPASS_EN
  assign bypass_valid = !fifo_valid && resp_keep;
  assign instr_valid  = fifo_valid || bypass_valid;
  assign instr        = fifo_valid ? head[31:0]  : (bypass_valid ? imem_rdata  : NOP);
  assign instr_pc     = fifo_valid ? head[63:32] : (bypass_valid ? resp_pc_reg : 32'h0);
`else
  assign bypass_valid = 1'b0;
  assign instr_valid  = fifo_valid;
  assign instr        = fifo_valid ? head[31:0]  : NOP;
  assign instr_pc     = fifo_valid ? head[63:32] : 32'h0;
`endif

  assign bypass_take = bypass_valid && instr_ready;
  assign pop_fifo    = fifo_valid && instr_ready && !redirect;
  assign push        = resp_keep && !bypass_take;

  always_comb begin
    occ_next         = occ_reg + CW'(push) - CW'(pop_fifo);
    wr_ptr_next      = wr_ptr_reg + PW'(push);
    rd_ptr_next      = rd_ptr_reg + PW'(pop_fifo);
    outstanding_next = outstanding_reg + CW'(issue) - CW'(imem_rvalid);
    drop_cnt_next    = drop_cnt_reg - CW'(resp_drop);
    fetch_pc_next    = issue ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
    resp_pc_next     = resp_keep ? resp_pc_reg + 32'd4 : resp_pc_reg;
    state_next       = state_reg;

    if (redirect) begin
      occ_next      = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      fetch_pc_next = redirect_pc_al;
      resp_pc_next  = redirect_pc_al;
      // Everything still in flight after this cycle becomes garbage to discard.
      if (state_reg == ST_RUN) begin
        drop_cnt_next = outstanding_reg - CW'(imem_rvalid);
      end
    end

    case (state_reg)
      ST_RUN:   if (drop_cnt_next != '0) state_next = ST_DRAIN;
      ST_DRAIN: if (drop_cnt_next == '0) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_RUN;
      fetch_pc_reg    <= {RESET_PC[31:2], 2'b00};
      resp_pc_reg     <= {RESET_PC[31:2], 2'b00};
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      occ_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      occ_reg         <= occ_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Storage needs no reset: occ gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {resp_pc_reg, imem_rdata};
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer: an in-order memory model plus a stream-level
// reference (tagged requests, expected fetch PC, queue of buffered words).
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_pc;
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_ready(1'b0), .redirect(1'b0), .redirect_pc(32'h0)
  );

  typedef struct packed { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        pend[$];
  ent_t        fq[$];
  logic [31:0] exp_fetch;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, iready_pct = 100, rvalid_pct = 100, redir_pm = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  int          n_issue = 0, n_pop = 0;
  int          first_issue = -1, first_valid = -1;
  int          w_n = 0;
  logic [31:0] w_addr [3];
  bit          watch_pop = 1'b0;
  logic [31:0] watch_pc = 32'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    bit   resp_now, good, drain, exp_req, exp_byp, exp_valid;
    ent_t hd;
    req_t r;
    @(posedge clk); #1;
    cyc++;
    imem_ready  = ($urandom_range(99) < ready_pct);
    instr_ready = ($urandom_range(99) < iready_pct);
    redirect    = force_redir || ($urandom_range(999) < redir_pm);
    if (force_redir) redirect_pc = force_pc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h3);
    else redirect_pc = $urandom & 32'h0000_FFFF;
    force_redir = 1'b0;
    resp_now    = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rvalid_pct);
    imem_rvalid = resp_now;
    imem_rdata  = resp_now ? memword(pend[0].addr) : $urandom;
    @(negedge clk);

    good  = resp_now && !pend[0].stale && !redirect;
    drain = 1'b0;
    foreach (pend[i]) if (pend[i].stale) drain = 1'b1;
    exp_req = !drain && !redirect && ((fq.size() + pend.size()) < DEPTH);
`ifdef PREFETCH_BYPASS_EN
    exp_byp = (fq.size() == 0) && good;
`else
    exp_byp = 1'b0;
`endif
    exp_valid = (fq.size() > 0) || exp_byp;

    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, exp_fetch);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      hd = (fq.size() > 0) ? fq[0] : '{pc: pend[0].addr, ins: memword(pend[0].addr)};
      check("instr_pc", instr_pc, hd.pc);
      check("instr", instr, hd.ins);
    end else begin
      check("instr_idle", instr, NOP);
      check("instr_pc_idle", instr_pc, 32'h0);
    end
    if (w_imem_req && imem_ready && w_n < 3) begin
      w_addr[w_n] = w_imem_addr;
      w_n++;
    end
    if (first_issue < 0 && exp_req && imem_ready) first_issue = cyc;
    if (first_valid < 0 && instr_valid) first_valid = cyc;

    r = '0;
    if (resp_now) r = pend.pop_front();
    if (redirect) begin
      fq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && instr_ready) begin
        n_pop++;
        $display("POP cyc=%0d pc=%h instr=%h", cyc, instr_pc, instr);
        if (watch_pop) begin
          watch_pc  = instr_pc;
          watch_pop = 1'b0;
        end
        if (fq.size() > 0) void'(fq.pop_front());
      end
      if (good && !(exp_byp && instr_ready)) fq.push_back('{pc: r.addr, ins: memword(r.addr)});
    end
    if (exp_req && imem_ready) begin
      pend.push_back('{addr: exp_fetch, due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
      n_issue++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    pend.delete(); fq.delete();
    exp_fetch = 32'h0; n_issue = 0; n_pop = 0; first_issue = -1; first_valid = -1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset();

    // Free-running sequential fetch, 1-cycle memory.
    lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100; rvalid_pct = 100; redir_pm = 0;
    repeat (20) step();
`ifdef PREFETCH_BYPASS_EN
    check("fetch_to_valid", 32'(first_valid - first_issue), 32'd1);
`else
    check("fetch_to_valid", 32'(first_valid - first_issue), 32'd2);
`endif
    check("wrap_addr0", w_addr[0], 32'hFFFF_FFF8);
    check("wrap_addr1", w_addr[1], 32'hFFFF_FFFC);
    check("wrap_addr2", w_addr[2], 32'h0000_0000);

    // Consumer stalled: credits cap issue at DEPTH.
    do_reset();
    iready_pct = 0;
    repeat (12) step();
    check("stall_issues", 32'(n_issue), 32'd4);
    check("stall_req_low", {31'b0, imem_req}, 32'h0);
    iready_pct = 100;
    step();
    check("one_pop", 32'(n_pop), 32'd1);
    iready_pct = 0;
    step();
    check("one_refill", 32'(n_issue), 32'd5);

    // Redirect with requests in flight on a 3-cycle memory.
    do_reset();
    iready_pct = 100; lat_min = 3; lat_max = 3;
    repeat (4) step();
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    watch_pop = 1'b1;
    repeat (12) step();
    check("redir_first_pc", watch_pc, 32'h0000_0100);

    // Randomized traffic with redirects.
    do_reset();
    lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 60; rvalid_pct = 80; redir_pm = 40;
    repeat (3000) step();
    check("random_progress", {31'b0, (n_pop > 100)}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
